// File: rtl/sap_alu_pkg.sv
// Shared types for the SAP ALU: opcode encoding, flag bit positions, sequencer states.
package sap_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_INC  = 4'd5,
    OP_DEC  = 4'd6,
    OP_CMP  = 4'd7,
    OP_MULL = 4'd8
  } op_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Opcodes 0..7 finish in the cycle EXEC is sampled.
  function automatic logic is_single_op(input logic [3:0] op);
    return (op <= 4'(OP_CMP));
  endfunction

endpackage

// File: rtl/sap_alu_if.sv
// W-bus side of the ALU: load/execute controls in, accumulator, flags and status pulses out.
// EXEC/LA/LB are sampled on a rising edge only while BUSY is low; VALID and ILLEGAL are single-cycle pulses.
interface sap_alu_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] BUS_IN;
  logic             LA;
  logic             LB;
  logic [3:0]       OP;
  logic             EXEC;
  logic             EU;
  logic [WIDTH-1:0] BUS_OUT;
  logic [WIDTH-1:0] ACC;
  logic [3:0]       FLAGS;
  logic             BUSY;
  logic             VALID;
  logic             ILLEGAL;

  modport master (
    output BUS_IN, LA, LB, OP, EXEC, EU,
    input  BUS_OUT, ACC, FLAGS, BUSY, VALID, ILLEGAL
  );

  modport slave (
    input  BUS_IN, LA, LB, OP, EXEC, EU,
    output BUS_OUT, ACC, FLAGS, BUSY, VALID, ILLEGAL
  );
endinterface

// File: rtl/sap_alu_core.sv
// Combinational adder-subtractor and logic unit for every single-cycle opcode.
// All arithmetic goes through one adder as a + addend + cin, so C=1 on subtract means no borrow.
module sap_alu_core
  import sap_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] addend;
  logic             cin;
  logic             use_adder;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   sum;

  always_comb begin
    addend    = b;
    cin       = 1'b0;
    use_adder = 1'b1;
    logic_res = '0;
    case (op)
      OP_ADD: begin
        addend = b;
      end
      OP_SUB, OP_CMP: begin
        addend = ~b;
        cin    = 1'b1;
      end
      OP_INC: begin
        addend = '0;
        cin    = 1'b1;
      end
      // a + ~1 + 1 keeps DEC on the same borrow convention as SUB.
      OP_DEC: begin
        addend = ~WIDTH'(1);
        cin    = 1'b1;
      end
      OP_AND: begin
        use_adder = 1'b0;
        logic_res = a & b;
      end
      OP_OR: begin
        use_adder = 1'b0;
        logic_res = a | b;
      end
      OP_XOR: begin
        use_adder = 1'b0;
        logic_res = a ^ b;
      end
      default: begin
        use_adder = 1'b0;
        logic_res = '0;
      end
    endcase

    sum    = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
    result = use_adder ? sum[WIDTH-1:0] : logic_res;

    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = use_adder & sum[WIDTH];
    flags[FLAG_V] = use_adder & (a[WIDTH-1] == addend[WIDTH-1]) &
                    (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/sap_alu_seq.sv
// Registered SAP ALU: A/B/FLAGS registers, IDLE/MUL sequencer and a WIDTH-step shift-add multiplier.
// Single-cycle ops write back on the EXEC edge; MULL writes back after WIDTH busy cycles.
module sap_alu_seq
  import sap_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic     CLK,
  input  logic     CLR_N,
  sap_alu_if.slave alu,
  output state_t   dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         flags_q, flags_d;
  logic               valid_q, valid_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic [WIDTH-1:0]   core_result;
  logic [3:0]         core_flags;
  logic [2*WIDTH-1:0] prod_step;
  logic               op_single;
  logic               op_mull;
  logic               op_writes_a;
  logic               mul_start;
  logic               mul_last;

  sap_alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (alu.OP),
    .result (core_result),
    .flags  (core_flags)
  );

  assign op_single   = is_single_op(alu.OP);
  assign op_mull     = MUL_EN && (alu.OP == 4'(OP_MULL));
  assign op_writes_a = op_single && (alu.OP != 4'(OP_CMP));
  assign mul_start   = (state_q == IDLE) && alu.EXEC && op_mull;
  assign mul_last    = (state_q == MUL) && (cnt_q == CNT_W'(WIDTH - 1));
  assign prod_step   = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Sequencer: state register.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer: outputs.
  always_comb begin
    alu.BUSY  = (state_q == MUL);
    dbg_state = state_q;
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    flags_d   = flags_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mplier_d  = mplier_q;

    case (state_q)
      IDLE: begin
        if (alu.LA) a_d = alu.BUS_IN;
        if (alu.LB) b_d = alu.BUS_IN;
        if (alu.EXEC) begin
          // Ops that own A's write-back override a same-cycle LA; B always sees its old value.
          if (op_single) begin
            if (op_writes_a) a_d = core_result;
            flags_d = core_flags;
            valid_d = 1'b1;
          end else if (op_mull) begin
            a_d      = a_q;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_q};
            mplier_d = b_q;
            prod_d   = '0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          a_d            = prod_step[WIDTH-1:0];
          flags_d        = '0;
          flags_d[FLAG_Z] = (prod_step[WIDTH-1:0] == '0);
          flags_d[FLAG_N] = prod_step[WIDTH-1];
          flags_d[FLAG_C] = |prod_step[2*WIDTH-1:WIDTH];
          valid_d        = 1'b1;
        end
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      a_q       <= '0;
      b_q       <= '0;
      flags_q   <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      mplier_q  <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      flags_q   <= flags_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      mplier_q  <= mplier_d;
    end
  end

  assign alu.BUS_OUT = alu.EU ? a_q : '0;
  assign alu.ACC     = a_q;
  assign alu.FLAGS   = flags_q;
  assign alu.VALID   = valid_q;
  assign alu.ILLEGAL = illegal_q;

endmodule

// File: tb/tb_sap_alu_seq.sv
// Directed bench for sap_alu_seq at WIDTH=8 with a result scoreboard fed at EXEC time.
module tb_sap_alu_seq;
  import sap_alu_pkg::*;

  logic   CLK;
  logic   CLR_N;
  state_t dbg_state;

  sap_alu_if #(.WIDTH(8)) alu_if ();

  sap_alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .alu       (alu_if),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int exp_valid = 0;
  int illegal_seen = 0;
  int exp_illegal = 0;

  logic [11:0] exp_q[$];
  logic [11:0] sb_e;
  logic [7:0]  a_m = 8'h00;
  logic [7:0]  b_m = 8'h00;
  int          busy_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {result[7:0], Z, N, C, V} from integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, full, sfull;
    logic [7:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    full = 0; sfull = 0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin full = ua + ub; sfull = sa + sb; c = (full > 255); end
      4'd1, 4'd7: begin full = ua - ub; sfull = sa - sb; c = (ua >= ub); end
      4'd2: full = ua & ub;
      4'd3: full = ua | ub;
      4'd4: full = ua ^ ub;
      4'd5: begin full = ua + 1; sfull = sa + 1; c = (ua == 255); end
      4'd6: begin full = ua - 1; sfull = sa - 1; c = (ua != 0); end
      4'd8: begin full = ua * ub; c = (full > 255); end
      default: full = 0;
    endcase
    if (op <= 4'd1 || (op >= 4'd5 && op <= 4'd7)) v = (sfull > 127) || (sfull < -128);
    r = full[7:0];
    return {r, (r == 8'h00), r[7], c, v};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic la, input logic lb, input logic [7:0] val);
    alu_if.LA = la; alu_if.LB = lb; alu_if.BUS_IN = val;
    if (la) a_m = val;
    if (lb) b_m = val;
    tick();
    alu_if.LA = 1'b0; alu_if.LB = 1'b0;
  endtask

  task automatic do_exec(input logic [3:0] op, input logic la, input logic lb, input logic [7:0] val);
    logic [11:0] r;
    logic [7:0]  new_a;
    alu_if.OP = op; alu_if.EXEC = 1'b1;
    alu_if.LA = la; alu_if.LB = lb; alu_if.BUS_IN = val;
    r = model(op, a_m, b_m);
    if (op <= 4'd8) begin
      new_a = (op == 4'd7) ? (la ? val : a_m) : r[11:4];
      exp_q.push_back({new_a, r[3:0]});
      exp_valid++;
    end else begin
      new_a = la ? val : a_m;
      exp_illegal++;
    end
    a_m = new_a;
    if (lb) b_m = val;
    tick();
    alu_if.EXEC = 1'b0; alu_if.LA = 1'b0; alu_if.LB = 1'b0;
  endtask

  task automatic wait_mul(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (alu_if.BUSY) n++;
      else break;
    end
  endtask

  // Scoreboard: every VALID pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (CLR_N && alu_if.VALID) begin
      valid_seen++;
      check("sb_expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        check("sb_result", {alu_if.ACC, alu_if.FLAGS}, sb_e);
      end
    end
    if (CLR_N && alu_if.ILLEGAL) illegal_seen++;
  end

  initial begin
    alu_if.BUS_IN = '0; alu_if.LA = 1'b0; alu_if.LB = 1'b0;
    alu_if.OP = '0; alu_if.EXEC = 1'b0; alu_if.EU = 1'b0;
    CLR_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_acc", alu_if.ACC, 8'h00);
    check("rst_flags", alu_if.FLAGS, 4'h0);
    check("rst_busy", alu_if.BUSY, 1'b0);
    check("rst_valid", alu_if.VALID, 1'b0);
    check("rst_illegal", alu_if.ILLEGAL, 1'b0);
    check("rst_state", dbg_state, IDLE);
    tick();
    CLR_N = 1'b1;

    // ADD with signed overflow
    do_load(1'b1, 1'b0, 8'h7F);
    do_load(1'b0, 1'b1, 8'h01);
    do_exec(4'd0, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("add_valid", alu_if.VALID, 1'b1);
    check("add_acc", alu_if.ACC, 8'h80);
    check("add_flags", alu_if.FLAGS, 4'b0101);
    @(negedge CLK);
    check("add_valid_once", alu_if.VALID, 1'b0);

    // SUB to zero, then CMP leaves A alone
    do_load(1'b1, 1'b1, 8'h05);
    do_exec(4'd1, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("sub_acc", alu_if.ACC, 8'h00);
    check("sub_flags", alu_if.FLAGS, 4'b1010);
    do_load(1'b1, 1'b0, 8'h03);
    do_load(1'b0, 1'b1, 8'h04);
    do_exec(4'd7, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("cmp_acc", alu_if.ACC, 8'h03);
    check("cmp_flags", alu_if.FLAGS, 4'b0100);
    do_exec(4'd7, 1'b1, 1'b0, 8'h20);
    @(negedge CLK);
    check("cmp_la_acc", alu_if.ACC, 8'h20);

    // INC / DEC wrap-around
    do_load(1'b1, 1'b0, 8'hFF);
    do_exec(4'd5, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("inc_acc", alu_if.ACC, 8'h00);
    check("inc_flags", alu_if.FLAGS, 4'b1010);
    do_exec(4'd6, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("dec_acc", alu_if.ACC, 8'hFF);
    check("dec_flags", alu_if.FLAGS, 4'b0100);
    alu_if.EU = 1'b1;
    #1 check("bus_out_en", alu_if.BUS_OUT, 8'hFF);
    alu_if.EU = 1'b0;
    #1 check("bus_out_dis", alu_if.BUS_OUT, 8'h00);

    // Back-to-back EXEC; first one also loads B (ADD must use old B=4)
    do_exec(4'd0, 1'b0, 1'b1, 8'h10);
    do_exec(4'd2, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("b2b_valid", alu_if.VALID, 1'b1);
    check("b2b_acc", alu_if.ACC, 8'h00);
    check("b2b_flags", alu_if.FLAGS, 4'b1000);
    do_exec(4'd3, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("or_acc", alu_if.ACC, 8'h10);

    // MULL 0x0F * 0x11
    do_load(1'b1, 1'b0, 8'h0F);
    do_load(1'b0, 1'b1, 8'h11);
    do_exec(4'd8, 1'b0, 1'b0, 8'h00);
    check("mul_state", dbg_state, MUL);
    wait_mul(busy_n);
    check("mul1_busy_cycles", busy_n, 8);
    check("mul1_valid", alu_if.VALID, 1'b1);
    check("mul1_acc", alu_if.ACC, 8'hFF);
    check("mul1_flags", alu_if.FLAGS, 4'b0100);

    // MULL 0x10 * 0x10 with LA + EXEC ADD attempted while busy
    do_load(1'b1, 1'b1, 8'h10);
    do_exec(4'd8, 1'b0, 1'b0, 8'h00);
    check("mul2_acc_busy", alu_if.ACC, 8'h10);
    tick();
    alu_if.LA = 1'b1; alu_if.BUS_IN = 8'hAA; alu_if.EXEC = 1'b1; alu_if.OP = 4'd0;
    tick();
    alu_if.LA = 1'b0; alu_if.EXEC = 1'b0;
    check("mul2_ignore_acc", alu_if.ACC, 8'h10);
    wait_mul(busy_n);
    check("mul2_busy_rest", busy_n, 6);
    check("mul2_acc", alu_if.ACC, 8'h00);
    check("mul2_flags", alu_if.FLAGS, 4'b1010);
    @(negedge CLK);
    check("mul2_valid_once", alu_if.VALID, 1'b0);

    // Reset during the 4th busy cycle discards the multiply
    do_load(1'b1, 1'b0, 8'h03);
    do_load(1'b0, 1'b1, 8'h05);
    do_exec(4'd8, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    check("mulrst_busy_before", alu_if.BUSY, 1'b1);
    CLR_N = 1'b0;
    exp_q.delete();
    exp_valid--;
    a_m = 8'h00; b_m = 8'h00;
    #1;
    check("mulrst_acc", alu_if.ACC, 8'h00);
    check("mulrst_flags", alu_if.FLAGS, 4'h0);
    check("mulrst_busy", alu_if.BUSY, 1'b0);
    check("mulrst_valid", alu_if.VALID, 1'b0);
    check("mulrst_state", dbg_state, IDLE);
    repeat (2) tick();
    CLR_N = 1'b1;
    repeat (12) tick();
    check("mulrst_quiet_acc", alu_if.ACC, 8'h00);
    do_load(1'b1, 1'b0, 8'h02);
    do_load(1'b0, 1'b1, 8'h03);
    do_exec(4'd0, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("post_rst_add", alu_if.ACC, 8'h05);

    // Illegal opcode
    do_exec(4'hF, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    check("ill_pulse", alu_if.ILLEGAL, 1'b1);
    check("ill_valid", alu_if.VALID, 1'b0);
    check("ill_acc", alu_if.ACC, 8'h05);
    check("ill_flags", alu_if.FLAGS, 4'h0);
    @(negedge CLK);
    check("ill_once", alu_if.ILLEGAL, 1'b0);

    // XOR with same-cycle LA: write-back wins
    do_load(1'b0, 1'b1, 8'hFF);
    do_exec(4'd4, 1'b1, 1'b0, 8'h55);
    @(negedge CLK);
    check("xor_la_acc", alu_if.ACC, 8'hFA);
    check("xor_la_flags", alu_if.FLAGS, 4'b0100);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    check("valid_count", valid_seen, exp_valid);
    check("illegal_count", illegal_seen, exp_illegal);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_alu_seq.md
Name: sap_alu_seq

Overview:
Parametrised, registered successor to the SAP-1 adder-subtractor. It holds an accumulator (A) and an operand register (B), both loaded from the W-bus, and executes a selectable operation set. A status-flag register (Z, N, C, V) records the result of each operation. Single-cycle ops complete on one edge; unsigned multiply is a WIDTH-cycle shift-add sequence with a BUSY/VALID handshake. The block sits on the W-bus between the controller-sequencer and the accumulator/output path.

Parameters:
WIDTH, 8, data width of A, B, bus and result (min 2).
MUL_EN, 1, 1 = MULL opcode implemented; 0 = MULL decodes as illegal.

Ports:
CLK  in  1  rising-edge clock
CLR_N  in  1  asynchronous active-low reset
BUS_IN  in  WIDTH  W-bus data
LA  in  1  load A from BUS_IN
LB  in  1  load B from BUS_IN
OP  in  4  opcode, sampled with EXEC
EXEC  in  1  execute request
EU  in  1  drive A onto BUS_OUT
BUS_OUT  out  WIDTH  EU ? A : 0 (combinational)
ACC  out  WIDTH  A register
FLAGS  out  4  {Z,N,C,V}, registered
BUSY  out  1  multiply in progress
VALID  out  1  one-cycle pulse: new A/FLAGS visible
ILLEGAL  out  1  one-cycle pulse: undefined opcode accepted

Behaviour:
- Reset (CLR_N low, async, any state including mid-multiply): A=0, B=0, FLAGS=0, BUSY=0, VALID=0, ILLEGAL=0, FSM=IDLE; any in-flight result is discarded.
- Opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 INC A; 6 DEC A; 7 CMP (A-B, flags only, A unchanged); 8 MULL (low WIDTH bits of unsigned A*B); 9-15 illegal.
- Arithmetic: SUB, CMP and DEC use A + ~operand + 1. C = carry-out, so C=1 means no borrow. V = signed overflow. Logic ops: C=0, V=0. Z = (result==0). N = result[WIDTH-1].
- MULL flags: C = (upper WIDTH bits of product != 0), V=0; Z and N from the low half.
- FSM has two states, IDLE and MUL.
  - IDLE: EXEC sampled high with a single-cycle op -> A (except CMP) and FLAGS update on that edge; VALID=1 for the following cycle.
  - IDLE: EXEC with MULL -> go to MUL, BUSY=1 from the next cycle, cycle counter cleared; operands are copied into internal shift registers.
  - MUL: one shift-add step per cycle. After exactly WIDTH cycles, A and FLAGS are written, return to IDLE, BUSY=0, VALID=1 for one cycle.
- Illegal opcode (or MULL with MUL_EN=0): no A/FLAGS change, VALID stays 0, ILLEGAL=1 for one cycle.
- While BUSY: EXEC, LA and LB are ignored with no side effects. BUS_OUT/ACC still show the old A.
- Simultaneous events in IDLE:
  - EXEC + LA: the EXEC write-back wins and LA is dropped; CMP/illegal do not write A, so LA takes effect for those.
  - EXEC + LB: the op uses the old B, and B loads on the same edge.
  - LA + LB: both load.
- Wrap-around: INC of all-ones -> 0, C=1, Z=1. DEC of 0 -> all-ones, C=0, N=1.
- Back-to-back EXEC on consecutive cycles is allowed for single-cycle ops; each produces its own VALID pulse.

Decomposition:
- Package sap_alu_pkg holds:
  - an op_t enum for the opcode values;
  - flag index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0;
  - a state_t enum {IDLE, MUL}.
- Sub-module sap_alu_core, combinational and parametrised on WIDTH:
  - takes A, B and op; returns result and {Z,N,C,V} for all single-cycle ops;
  - is the generalised adder-subtractor.
- The top level holds registers, FSM, the shift-add multiplier and the handshake.

Test Plan:
- WIDTH=8; reset; LA 0x7F, LB 0x01, EXEC ADD -> next cycle ACC=0x80, FLAGS Z0 N1 C0 V1, VALID high exactly one cycle.
- A=0x05, B=0x05, SUB -> ACC=0x00, Z1 C1. Then LA 0x03, LB 0x04, CMP -> ACC stays 0x03, Z0 N1 C0 V0.
- A=0xFF, INC -> ACC=0x00, Z1 C1. Then DEC -> ACC=0xFF, N1 C0.
- A=0x0F, B=0x11, MULL -> BUSY high exactly 8 cycles, ACC=0xFF, C0. Then A=0x10, B=0x10, MULL -> ACC=0x00, Z1 C1. LA 0xAA and EXEC ADD issued mid-BUSY -> no effect.
- Start MULL, drop CLR_N on the 4th BUSY cycle -> ACC, FLAGS, BUSY all 0 immediately, no VALID. After release, ADD 0x02+0x03 -> ACC=0x05.
- OP=0xF with EXEC -> ILLEGAL one-cycle pulse, ACC/FLAGS unchanged, VALID=0. Then LA 0x55 + EXEC XOR (B=0xFF) same cycle -> ACC=old A^0xFF, LA dropped.
